complex_eight_dot_product_multiply_with_control: RTL and testbench

- Streaming complex dot-product engine: each beat takes 8 complex lanes from each of two vectors, multiplies them lane-wise and accumulates.
- Over ceil(NOE/8) accepted beats it produces one complex scalar plus a one-cycle finish pulse.
- Sits under the vector×vector wrapper of the solver cluster, which feeds zero-padded row/vector slices and gates input with outsider_read_now.

---
 rtl/complex_eight_dot_product_multiply_with_control_if.sv | 24 ++
 rtl/complex_eight_dot_product_multiply_with_control.sv | 113 +++++++++++
 tb/tb_complex_eight_dot_product_multiply_with_control.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/complex_eight_dot_product_multiply_with_control_if.sv
// Beat stream into the complex dot-product engine and the completed scalar back out.
// outsider_read_now is the beat-valid: a beat moves only on a rising edge where it is high.
// There is no ready, because the engine accepts one beat every clock.
// finish is a one-cycle strobe, and result is valid from that cycle until the next strobe.
interface complex_eight_dot_product_multiply_with_control_if #(
  parameter int element_width = 64,
  parameter int no_of_units   = 8
);
  logic [element_width*no_of_units-1:0] first_row;
  logic [element_width*no_of_units-1:0] second_row;
  logic                                 outsider_read_now;
  logic [element_width-1:0]             result;
  logic                                 finish;

  modport master (
    output first_row, second_row, outsider_read_now,
    input  result, finish
  );

  modport slave (
    input  first_row, second_row, outsider_read_now,
    output result, finish
  );
endinterface

// File: rtl/complex_eight_dot_product_multiply_with_control.sv
// Three-stage streaming complex dot product: lane products, adder tree, accumulate.
// It emits one wrapped 32+32-bit complex result every ceil(NOE/8) accepted beats.
module complex_eight_dot_product_multiply_with_control #(
  parameter int NOE           = 16,
  parameter int element_width = 64,
  parameter int no_of_units   = 8
) (
  input logic clk,
  input logic reset,
  complex_eight_dot_product_multiply_with_control_if.slave bus
);

  localparam int BEATS = (NOE + no_of_units - 1) / no_of_units;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HALF  = element_width / 2;
  localparam int PW    = element_width + 1;
  localparam int SW    = element_width + 4;

  logic signed [PW-1:0] lane_re [no_of_units];
  logic signed [PW-1:0] lane_im [no_of_units];

  for (genvar g = 0; g < no_of_units; g++) begin : g_lane
    logic signed [HALF-1:0]          ar, ai, br, bi;
    logic signed [element_width-1:0] p_rr, p_ii, p_ri, p_ir;

    assign ar = bus.first_row [g*element_width + HALF +: HALF];
    assign ai = bus.first_row [g*element_width        +: HALF];
    assign br = bus.second_row[g*element_width + HALF +: HALF];
    assign bi = bus.second_row[g*element_width        +: HALF];

    assign p_rr = element_width'(ar) * element_width'(br);
    assign p_ii = element_width'(ai) * element_width'(bi);
    assign p_ri = element_width'(ar) * element_width'(bi);
    assign p_ir = element_width'(ai) * element_width'(br);

    assign lane_re[g] = PW'(p_rr) - PW'(p_ii);
    assign lane_im[g] = PW'(p_ri) + PW'(p_ir);
  end

  logic [CNT_W-1:0]     beat_cnt;
  logic signed [PW-1:0] s1_re [no_of_units];
  logic signed [PW-1:0] s1_im [no_of_units];
  logic                 s1_valid, s1_last;
  logic signed [SW-1:0] s2_re, s2_im;
  logic                 s2_valid, s2_last;
  logic signed [SW-1:0] acc_re, acc_im;
  logic signed [SW-1:0] tree_re, tree_im;
  logic signed [SW-1:0] acc_next_re, acc_next_im;

  always_comb begin
    tree_re = '0;
    tree_im = '0;
    for (int i = 0; i < no_of_units; i++) begin
      tree_re = tree_re + SW'(s1_re[i]);
      tree_im = tree_im + SW'(s1_im[i]);
    end
  end

  // The accumulator may wrap across long vectors, but only its low 32 bits are ever reported.
  assign acc_next_re = acc_re + s2_re;
  assign acc_next_im = acc_im + s2_im;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt   <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      for (int i = 0; i < no_of_units; i++) begin
        s1_re[i] <= '0;
        s1_im[i] <= '0;
      end
      s2_re      <= '0;
      s2_im      <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      acc_re     <= '0;
      acc_im     <= '0;
      bus.result <= '0;
      bus.finish <= 1'b0;
    end else begin
      s1_valid <= bus.outsider_read_now;
      s1_last  <= bus.outsider_read_now && (beat_cnt == CNT_W'(BEATS - 1));
      if (bus.outsider_read_now) begin
        beat_cnt <= (beat_cnt == CNT_W'(BEATS - 1)) ? '0 : beat_cnt + CNT_W'(1);
        for (int i = 0; i < no_of_units; i++) begin
          s1_re[i] <= lane_re[i];
          s1_im[i] <= lane_im[i];
        end
      end

      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        s2_re <= tree_re;
        s2_im <= tree_im;
      end

      bus.finish <= 1'b0;
      if (s2_valid) begin
        if (s2_last) begin
          bus.result <= {acc_next_re[HALF-1:0], acc_next_im[HALF-1:0]};
          bus.finish <= 1'b1;
          acc_re     <= '0;
          acc_im     <= '0;
        end else begin
          acc_re <= acc_next_re;
          acc_im <= acc_next_im;
        end
      end
    end
  end

endmodule

// File: tb/tb_complex_eight_dot_product_multiply_with_control.sv
// Directed bench: two engines (NOE=16 and NOE=12) are driven with hand-computed vectors.
// Expected results and finish timing are checked against fixed constants.
module tb_complex_eight_dot_product_multiply_with_control;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  complex_eight_dot_product_multiply_with_control_if bus16 ();
  complex_eight_dot_product_multiply_with_control_if bus12 ();

  complex_eight_dot_product_multiply_with_control #(.NOE(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  complex_eight_dot_product_multiply_with_control #(.NOE(12)) dut12 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus12.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] fill(input logic [31:0] re, input logic [31:0] im);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[64*i +: 64] = {re, im};
    return r;
  endfunction

  function automatic logic [511:0] garbage();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // driver tasks
  task automatic send_beat(input bit use12, input logic [511:0] a, input logic [511:0] b);
    @(negedge clk);
    if (use12) begin
      bus12.first_row = a; bus12.second_row = b; bus12.outsider_read_now = 1'b1;
    end else begin
      bus16.first_row = a; bus16.second_row = b; bus16.outsider_read_now = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus16.outsider_read_now = 1'b0;
      bus16.first_row  = garbage();
      bus16.second_row = garbage();
      bus12.outsider_read_now = 1'b0;
    end
  endtask

  // Counts negedges after the last beat until finish; the expected value is 3.
  task automatic wait_finish(input bit use12, input string tag, input logic [63:0] exp_res);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      bus16.outsider_read_now = 1'b0;
      bus12.outsider_read_now = 1'b0;
      lat++;
      seen = use12 ? bus12.finish : bus16.finish;
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_result"}, use12 ? bus12.result : bus16.result, exp_res);
    @(negedge clk);
    check({tag, "_pulse_end"}, 64'(use12 ? bus12.finish : bus16.finish), 64'd0);
  endtask

  logic [511:0] a_v, b_v;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus16.outsider_read_now = 1'b0;
    bus16.first_row = '0; bus16.second_row = '0;
    bus12.outsider_read_now = 1'b0;
    bus12.first_row = '0; bus12.second_row = '0;
    #1;
    check("reset_result16", bus16.result, 64'd0);
    check("reset_finish16", 64'(bus16.finish), 64'd0);
    check("reset_result12", bus12.result, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Test 1: (1+2j)(3+4j) * 16 = -80+160j
    send_beat(0, fill(32'd1, 32'd2), fill(32'd3, 32'd4));
    send_beat(0, fill(32'd1, 32'd2), fill(32'd3, 32'd4));
    wait_finish(0, "t1", {32'hFFFFFFB0, 32'h000000A0});
    idle(2);

    // Test 2: single lane 5 * 7j = 35j, with no finish after beat 0 alone
    a_v = '0; b_v = '0;
    a_v[64*3 +: 64] = {32'd5, 32'd0};
    b_v[64*3 +: 64] = {32'd0, 32'd7};
    send_beat(0, a_v, b_v);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("t2_no_early_finish", 64'(bus16.finish), 64'd0);
    end
    send_beat(0, '0, '0);
    wait_finish(0, "t2", {32'd0, 32'd35});
    idle(2);

    // Test 3: bubble of 3 cycles carrying garbage between the two beats
    send_beat(0, fill(32'd1, 32'd2), fill(32'd3, 32'd4));
    idle(3);
    send_beat(0, fill(32'd1, 32'd2), fill(32'd3, 32'd4));
    wait_finish(0, "t3", {32'hFFFFFFB0, 32'h000000A0});
    idle(2);

    // Test 4: reset after beat 0 discards it
    send_beat(0, fill(32'd1, 32'd2), fill(32'd3, 32'd4));
    @(negedge clk);
    bus16.outsider_read_now = 1'b0;
    reset = 1'b0;
    #1;
    check("t4_reset_result", bus16.result, 64'd0);
    check("t4_reset_finish", 64'(bus16.finish), 64'd0);
    @(negedge clk);
    check("t4_reset_result_hold", bus16.result, 64'd0);
    reset = 1'b1;
    send_beat(0, fill(32'd1, 32'd0), fill(32'd2, 32'd0));
    send_beat(0, fill(32'd1, 32'd0), fill(32'd2, 32'd0));
    wait_finish(0, "t4", {32'd32, 32'd0});
    idle(2);

    // Test 5: NOE=12, (1+1j)(1-1j)=2 per active lane, 12 lanes -> 24
    send_beat(1, fill(32'd1, 32'd1), fill(32'd1, 32'hFFFFFFFF));
    a_v = fill(32'd1, 32'd1);
    b_v = fill(32'd1, 32'hFFFFFFFF);
    a_v[511:256] = '0;
    b_v[511:256] = '0;
    send_beat(1, a_v, b_v);
    wait_finish(1, "t5", {32'd24, 32'd0});
    idle(2);

    // Test 6: back-to-back vectors, finish pulses 2 cycles apart
    send_beat(0, fill(32'd1, 32'd2), fill(32'd3, 32'd4));
    send_beat(0, fill(32'd1, 32'd2), fill(32'd3, 32'd4));
    send_beat(0, fill(32'd0, 32'd1), fill(32'd0, 32'd1));
    send_beat(0, fill(32'd0, 32'd1), fill(32'd0, 32'd1));
    idle(1);
    check("t6_finish_a", 64'(bus16.finish), 64'd1);
    check("t6_result_a", bus16.result, {32'hFFFFFFB0, 32'h000000A0});
    idle(1);
    check("t6_gap", 64'(bus16.finish), 64'd0);
    check("t6_result_hold", bus16.result, {32'hFFFFFFB0, 32'h000000A0});
    idle(1);
    check("t6_finish_b", 64'(bus16.finish), 64'd1);
    check("t6_result_b", bus16.result, {32'hFFFFFFF0, 32'h00000000});
    idle(1);
    check("t6_pulse_end", 64'(bus16.finish), 64'd0);
    idle(3);
    check("t6_result_final_hold", bus16.result, {32'hFFFFFFF0, 32'h00000000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
